// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store per MemEn assertion, with WAIT_CYCLES
// wait states in front of a word-addressed RAM and a one-cycle ready/err response.
module data_mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemEn,
    input  logic              MemWen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic              cap_wen;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              do_access;
    logic              acc_wen;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] ram [DEPTH];

    always_comb begin
        next_state = state;
        do_access  = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemEn) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = S_RESP;
                        do_access  = 1'b1;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    next_state = S_RESP;
                    do_access  = 1'b1;
                end
            end
            S_RESP: next_state = S_HOLD;
            S_HOLD: begin
                if (!MemEn) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A zero-wait access happens on the sampling edge itself, so it uses the live inputs.
    always_comb begin
        acc_wen   = cap_wen;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (state == S_IDLE) begin
            acc_wen   = MemWen;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
        in_range = 32'(acc_addr) < 32'(DEPTH);
        idx      = acc_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap_wen   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != S_IDLE);
            ready <= do_access;
            err   <= do_access && !in_range;
            if (state == S_IDLE && MemEn) begin
                cap_wen   <= MemWen;
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cnt       <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access && !acc_wen) begin
                rdata <= in_range ? ram[idx] : '0;
            end
        end
    end

    // RAM is not reset; a reset before the access edge returns to IDLE and blocks the write.
    always_ff @(posedge clk) begin
        if (do_access && acc_wen && in_range) begin
            ram[idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances cover WAIT_CYCLES 2, 0
// (with DEPTH 1000) and 3; inputs change and outputs are sampled on the falling edge.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset_a, en_a, wen_a, ready_a, err_a, busy_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a, rdata_a;
    logic        reset_b, en_b, wen_b, ready_b, err_b, busy_b;
    logic [9:0]  addr_b;
    logic [31:0] wdata_b, rdata_b;
    logic        reset_c, en_c, wen_c, ready_c, err_c, busy_c;
    logic [9:0]  addr_c;
    logic [31:0] wdata_c, rdata_c;

    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .reset(reset_a), .MemEn(en_a), .MemWen(wen_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset_b), .MemEn(en_b), .MemWen(wen_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT_CYCLES(3)) u_c (
        .clk(clk), .reset(reset_c), .MemEn(en_c), .MemWen(wen_c), .addr(addr_c),
        .wdata(wdata_c), .rdata(rdata_c), .ready(ready_c), .err(err_c), .busy(busy_c)
    );

    task automatic req_b(input logic w, input logic [9:0] a, input logic [31:0] d);
        en_b = 1'b1; wen_b = w; addr_b = a; wdata_b = d;
        @(negedge clk);
    endtask

    task automatic drop_b;
        en_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
        en_a = 1'b0; wen_a = 1'b0; addr_a = '0; wdata_a = '0;
        en_b = 1'b0; wen_b = 1'b0; addr_b = '0; wdata_b = '0;
        en_c = 1'b0; wen_c = 1'b0; addr_c = '0; wdata_c = '0;
        repeat (2) @(negedge clk);
        checks++; if ({ready_a, err_a, busy_a} !== 3'b000) begin errors++; $display("FAIL reset_a_flags: got %b expected 000", {ready_a, err_a, busy_a}); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", rdata_a); end
        checks++; if ({ready_b, err_b, busy_b} !== 3'b000) begin errors++; $display("FAIL reset_b_flags: got %b expected 000", {ready_b, err_b, busy_b}); end
        checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 0", rdata_b); end
        checks++; if ({ready_c, err_c, busy_c} !== 3'b000) begin errors++; $display("FAIL reset_c_flags: got %b expected 000", {ready_c, err_c, busy_c}); end
        checks++; if (rdata_c !== 32'h0) begin errors++; $display("FAIL reset_c_rdata: got %h expected 0", rdata_c); end
        reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait2_store_load;
        en_a = 1'b1; wen_a = 1'b1; addr_a = 10'd5; wdata_a = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (ready_a !== (c == 3)) begin errors++; $display("FAIL w2_store_ready c%0d: got %b expected %b", c, ready_a, (c == 3)); end
            checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL w2_store_busy c%0d: got %b expected 1", c, busy_a); end
            if (c == 3) begin
                checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL w2_store_err: got %b expected 0", err_a); end
            end
        end
        en_a = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL w2_busy_fall: got %b expected 0", busy_a); end
        en_a = 1'b1; wen_a = 1'b0; addr_a = 10'd5; wdata_a = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++; if (ready_a !== (c == 3)) begin errors++; $display("FAIL w2_load_ready c%0d: got %b expected %b", c, ready_a, (c == 3)); end
            if (c >= 3) begin
                checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL w2_load_rdata c%0d: got %h expected deadbeef", c, rdata_a); end
            end
            if (c == 3) begin
                checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL w2_load_err: got %b expected 0", err_a); end
            end
        end
        en_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_capture;
        en_a = 1'b1; wen_a = 1'b1; addr_a = 10'd9; wdata_a = 32'h11112222;
        @(negedge clk);
        wen_a = 1'b0; addr_a = 10'd10; wdata_a = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL cap_ready: got %b expected 1", ready_a); end
        checks++; if (rdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL cap_rdata_kept: got %h expected deadbeef", rdata_a); end
        en_a = 1'b0;
        repeat (2) @(negedge clk);
        en_a = 1'b1; wen_a = 1'b0; addr_a = 10'd9;
        repeat (3) @(negedge clk);
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL cap_load_ready: got %b expected 1", ready_a); end
        checks++; if (rdata_a !== 32'h11112222) begin errors++; $display("FAIL cap_load_rdata: got %h expected 11112222", rdata_a); end
        en_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hold_high;
        int pulses;
        int busy_lo;
        pulses = 0; busy_lo = 0;
        en_a = 1'b1; wen_a = 1'b0; addr_a = 10'd5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ready_a === 1'b1) pulses++;
            if (busy_a !== 1'b1) busy_lo++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulses); end
        checks++; if (busy_lo !== 0) begin errors++; $display("FAIL hold_busy_low_cycles: got %0d expected 0", busy_lo); end
        en_a = 1'b0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL hold_busy_fall: got %b expected 0", busy_a); end
        en_a = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (ready_a === 1'b1) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_repulse: got %0d expected 1", pulses); end
        en_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_wait;
        req_b(1'b1, 10'd0, 32'h1);
        checks++; if ({ready_b, err_b, busy_b} !== 3'b101) begin errors++; $display("FAIL w0_store_resp: got %b expected 101", {ready_b, err_b, busy_b}); end
        en_b = 1'b0;
        @(negedge clk);
        checks++; if ({ready_b, busy_b} !== 2'b01) begin errors++; $display("FAIL w0_hold: got %b expected 01", {ready_b, busy_b}); end
        @(negedge clk);
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL w0_idle: got %b expected 0", busy_b); end
        req_b(1'b0, 10'd0, 32'h0);
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL w0_load_ready: got %b expected 1", ready_b); end
        checks++; if (rdata_b !== 32'h1) begin errors++; $display("FAIL w0_load_rdata: got %h expected 1", rdata_b); end
        drop_b();
    endtask

    task automatic test_out_of_range;
        req_b(1'b1, 10'd23, 32'hCAFE);
        drop_b();
        req_b(1'b0, 10'd23, 32'h0);
        checks++; if (rdata_b !== 32'hCAFE) begin errors++; $display("FAIL oor_pre_load: got %h expected cafe", rdata_b); end
        drop_b();
        req_b(1'b1, 10'd1023, 32'hFF);
        checks++; if ({ready_b, err_b} !== 2'b11) begin errors++; $display("FAIL oor_store_err: got %b expected 11", {ready_b, err_b}); end
        checks++; if (rdata_b !== 32'hCAFE) begin errors++; $display("FAIL oor_store_rdata: got %h expected cafe", rdata_b); end
        en_b = 1'b0;
        @(negedge clk);
        checks++; if ({ready_b, err_b} !== 2'b00) begin errors++; $display("FAIL oor_err_clear: got %b expected 00", {ready_b, err_b}); end
        @(negedge clk);
        req_b(1'b0, 10'd1000, 32'h0);
        checks++; if ({ready_b, err_b} !== 2'b11) begin errors++; $display("FAIL oor_load_err: got %b expected 11", {ready_b, err_b}); end
        checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL oor_load_rdata: got %h expected 0", rdata_b); end
        drop_b();
        req_b(1'b0, 10'd23, 32'h0);
        checks++; if ({ready_b, err_b} !== 2'b10) begin errors++; $display("FAIL oor_alias_flags: got %b expected 10", {ready_b, err_b}); end
        checks++; if (rdata_b !== 32'hCAFE) begin errors++; $display("FAIL oor_alias_rdata: got %h expected cafe", rdata_b); end
        drop_b();
    endtask

    task automatic test_reset_abort;
        en_c = 1'b1; wen_c = 1'b1; addr_c = 10'd7; wdata_c = 32'h1234;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if (ready_c !== (c == 4)) begin errors++; $display("FAIL w3_store_ready c%0d: got %b expected %b", c, ready_c, (c == 4)); end
        end
        en_c = 1'b0;
        repeat (2) @(negedge clk);
        en_c = 1'b1; wen_c = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (rdata_c !== 32'h1234) begin errors++; $display("FAIL w3_load_rdata: got %h expected 1234", rdata_c); end
        en_c = 1'b0;
        repeat (2) @(negedge clk);
        en_c = 1'b1; wen_c = 1'b1; wdata_c = 32'hAAAA;
        repeat (2) @(negedge clk);
        reset_c = 1'b1; en_c = 1'b0;
        #1;
        checks++; if ({ready_c, err_c, busy_c} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", {ready_c, err_c, busy_c}); end
        checks++; if (rdata_c !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", rdata_c); end
        @(negedge clk);
        reset_c = 1'b0;
        @(negedge clk);
        en_c = 1'b1; wen_c = 1'b0; addr_c = 10'd7;
        repeat (4) @(negedge clk);
        checks++; if (ready_c !== 1'b1) begin errors++; $display("FAIL abort_load_ready: got %b expected 1", ready_c); end
        checks++; if (rdata_c !== 32'h1234) begin errors++; $display("FAIL abort_load_rdata: got %h expected 1234", rdata_c); end
        en_c = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_wait2_store_load();
        test_capture();
        test_hold_high();
        test_zero_wait();
        test_out_of_range();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the datapath's data-memory request interface (`MemEn`/`MemWen`). Accepts one load or store request at a time from the control unit/datapath, inserts a parameterised number of wait states, performs the access on an internal word-addressed RAM, and returns a one-cycle `ready` pulse with read data and an error flag. The block replaces the zero-latency data memory, so the control path can be exercised against realistic memory latency.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `ADDR_W`, 10: address width (word address).
- `DEPTH`, 1024: implemented words; must be ≤ 2^`ADDR_W`.
- `WAIT_CYCLES`, 1: wait states inserted per access; range 0..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemEn`  in  1  request; level, return-to-zero between requests.
- `MemWen`  in  1  1 = store, 0 = load; sampled with the request.
- `addr`  in  `ADDR_W`  word address; sampled with the request.
- `wdata`  in  `DATA_W`  store data; sampled with the request.
- `rdata`  out  `DATA_W`  load data; valid while `ready` = 1, held until the next load response.
- `ready`  out  1  one-cycle response pulse.
- `err`  out  1  valid with `ready`; 1 = address ≥ `DEPTH`.
- `busy`  out  1  1 whenever state ≠ IDLE.

## Operation
- States: IDLE, WAIT, RESP, HOLD.
- IDLE: when `MemEn` = 1 at a rising edge, capture `MemWen`, `addr`, and `wdata`, load the wait counter with `WAIT_CYCLES`, and go to WAIT. If `WAIT_CYCLES` = 0, go directly to RESP and perform the access on that same edge.
- WAIT: decrement the counter each edge. On the edge where the counter reaches 0, perform the access and go to RESP. Input changes during WAIT are ignored.
- Access, in-range store: write the captured `wdata` to RAM[captured `addr`]; `rdata` is unchanged.
- Access, in-range load: register RAM[captured `addr`] into `rdata`.
- Access, out-of-range (addr ≥ `DEPTH`): no RAM write; `rdata` <= 0 for a load and is unchanged for a store; `err` <= 1.
- RESP: `ready` = 1 for exactly one cycle, then go to HOLD.
- HOLD: wait for `MemEn` = 0, then go to IDLE. This is one response per `MemEn` assertion: a requester that holds `MemEn` high across several cycles, as the control unit does for loads through EXECUTE and WRITEBACK, gets exactly one access. A new request requires `MemEn` low for at least one sampled edge.
- `err` is registered together with `ready` and is 0 whenever `ready` = 0.
- Reset (asynchronous, any state):
  - state → IDLE, counter → 0.
  - `ready`, `err`, `busy` → 0; `rdata` → 0.
  - RAM contents are not cleared.
  - An aborted request performs no write unless its access edge has already occurred.

## Timing
- Request sampled at edge E0. The access occurs at edge E0+`WAIT_CYCLES` (E0 itself when `WAIT_CYCLES` = 0). `ready` is high from E0+`WAIT_CYCLES` to E0+`WAIT_CYCLES`+1.
- Load-to-data latency is `WAIT_CYCLES`+1 cycles.
- `busy` rises the cycle after E0 and falls the cycle after `MemEn` is seen low in HOLD.
- Minimum request spacing with `WAIT_CYCLES` = 0 is 3 cycles: IDLE, RESP, HOLD with `MemEn` low.
- All outputs are registered; no combinational input-to-output path.
- A store followed by a load to the same address returns the new data, because the store commits at its access edge, before any later request.

## Test plan
- `WAIT_CYCLES` = 2: store 0xDEADBEEF to addr 5, drop `MemEn`, then load addr 5 → `ready` exactly 3 cycles after the load is sampled, `rdata` = 0xDEADBEEF, `err` = 0.
- `WAIT_CYCLES` = 0: pulse requests (store 0x1 to addr 0, load addr 0) with one low cycle between them → each `ready` arrives 1 cycle after sampling; the load returns 0x1.
- `DEPTH` = 1000: load addr 1000 → `ready` = 1, `err` = 1, `rdata` = 0. Store 0xFF to addr 1023 → `err` = 1, and RAM[1023 mod 1000] is unchanged.
- Hold `MemEn` high for 10 cycles on a load → exactly one `ready` pulse. `busy` stays high until `MemEn` falls. A second pulse occurs only after `MemEn` goes low and is reasserted.
- `WAIT_CYCLES` = 3: assert `reset` during WAIT of a store of 0xAAAA to addr 7 (old value 0x1234) → all outputs 0 immediately; a subsequent load of addr 7 returns 0x1234.
- Change `addr`/`wdata`/`MemWen` during WAIT → the access uses the values captured at E0.
